control_unit: RTL and testbench

//  Multi-cycle FSM controller for the processor datapath. Fetches 16-bit instructions

---
 rtl/cu_pkg.sv | 57 +++++
 rtl/pc_counter.sv | 16 +
 rtl/control_unit.sv | 142 ++++++++++++++
 tb/tb_control_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and instruction-field positions for the processor control unit.
package cu_pkg;

  localparam int IR_W     = 16;
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 8;
  localparam int RB_MSB   = 7;
  localparam int RB_LSB   = 4;
  localparam int RC_MSB   = 3;
  localparam int RC_LSB   = 0;
  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 0;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } op_t;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_STORE  = 4'd4,
    S_LOAD_A = 4'd5,
    S_LOAD_B = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9,
    S_WAIT   = 4'd10
  } state_t;

  // Unused opcodes 6..F fall through to NOOP.
  function automatic state_t exec_state(input logic [IR_W-1:0] ir);
    state_t s;
    case (op_t'(ir[OP_MSB:OP_LSB]))
      OP_STORE: s = S_STORE;
      OP_LOAD:  s = S_LOAD_A;
      OP_ADD:   s = S_ADD;
      OP_SUB:   s = S_SUB;
      OP_HALT:  s = S_HALT;
      default:  s = S_NOOP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: async active-low clear, synchronous increment, wraps silently.
module pc_counter #(
  parameter int W = 7
) (
  input  logic         clk_sys,
  input  logic         rst_b,
  input  logic         inc,
  output logic [W-1:0] pc
);

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b)   pc <= '0;
    else if (inc) pc <= pc + W'(1);
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute controller with registered Moore outputs.
// Optional single-step mode when CU_STEP_EN is defined (adds Step input and WAIT state).
//
// state  | meaning
// INIT   | first cycle after reset release
// FETCH  | PC presented to instruction ROM
// DECODE | ROM data captured into IR, PC advanced
// NOOP   | no operation (also opcodes 6..F)
// STORE  | mem[IR[7:0]] <= R[IR[11:8]]
// LOAD_A | data-memory read issued
// LOAD_B | read data written back to R[IR[11:8]]
// ADD    | R[d] <= R[b] + R[c]
// SUB    | R[d] <= R[b] - R[c]
// HALT   | terminal until reset
// WAIT   | step mode only: idle until a Step edge
module control_unit
  import cu_pkg::*;
#(
  parameter int PC_W = 7,
  parameter int DA_W = 8,
  parameter int RA_W = 4
) (
  input  logic            Clk,
  input  logic            ResetN,
`ifdef CU_STEP_EN
  input  logic            Step,
`endif
  input  logic [IR_W-1:0] IR_Data,
  output logic [PC_W-1:0] PC_Addr,
  output logic [DA_W-1:0] D_Addr,
  output logic            D_Wr,
  output logic            RF_s,
  output logic [RA_W-1:0] RF_W_addr,
  output logic            RF_W_en,
  output logic [RA_W-1:0] RF_Ra_addr,
  output logic [RA_W-1:0] RF_Rb_addr,
  output logic [2:0]      ALU_s0,
  output logic [3:0]      State
);

  state_t          state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            pc_inc;

  assign ir_d   = (state_q == S_DECODE) ? IR_Data : ir_q;
  assign pc_inc = (state_q == S_DECODE);
  assign State  = state_q;

  pc_counter #(.W(PC_W)) u_pc (
    .clk_sys (Clk),
    .rst_b   (ResetN),
    .inc     (pc_inc),
    .pc      (PC_Addr)
  );

`ifdef CU_STEP_EN
  logic step_q, step_pend, step_go;
  assign step_go = (Step & ~step_q) | step_pend;

  // An edge seen mid-instruction is remembered until the next WAIT.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      step_q    <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      step_q <= Step;
      if (state_q == S_WAIT && step_go) step_pend <= 1'b0;
      else if (Step & ~step_q)          step_pend <= 1'b1;
    end
  end

  localparam state_t S_DONE = S_WAIT;
`else
  localparam state_t S_DONE = S_FETCH;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = exec_state(IR_Data);
      S_LOAD_A: state_d = S_LOAD_B;
      S_NOOP, S_STORE, S_LOAD_B, S_ADD, S_SUB: state_d = S_DONE;
`ifdef CU_STEP_EN
      S_WAIT:   if (step_go) state_d = S_FETCH;
`endif
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // Outputs are registered from the next state and next IR so they line up with State.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= S_INIT;
      ir_q       <= '0;
      D_Addr     <= '0;
      D_Wr       <= 1'b0;
      RF_s       <= 1'b0;
      RF_W_addr  <= '0;
      RF_W_en    <= 1'b0;
      RF_Ra_addr <= '0;
      RF_Rb_addr <= '0;
      ALU_s0     <= ALU_PASS;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      D_Addr     <= '0;
      D_Wr       <= 1'b0;
      RF_s       <= 1'b0;
      RF_W_addr  <= '0;
      RF_W_en    <= 1'b0;
      RF_Ra_addr <= '0;
      RF_Rb_addr <= '0;
      ALU_s0     <= ALU_PASS;
      case (state_d)
        S_STORE: begin
          D_Wr       <= 1'b1;
          D_Addr     <= DA_W'(ir_d[ADDR_MSB:ADDR_LSB]);
          RF_Ra_addr <= RA_W'(ir_d[RD_MSB:RD_LSB]);
        end
        S_LOAD_A: D_Addr <= DA_W'(ir_d[ADDR_MSB:ADDR_LSB]);
        S_LOAD_B: begin
          D_Addr    <= DA_W'(ir_d[ADDR_MSB:ADDR_LSB]);
          RF_s      <= 1'b1;
          RF_W_en   <= 1'b1;
          RF_W_addr <= RA_W'(ir_d[RD_MSB:RD_LSB]);
        end
        S_ADD, S_SUB: begin
          RF_Ra_addr <= RA_W'(ir_d[RB_MSB:RB_LSB]);
          RF_Rb_addr <= RA_W'(ir_d[RC_MSB:RC_LSB]);
          ALU_s0     <= (state_d == S_ADD) ? ALU_ADD : ALU_SUB;
          RF_W_en    <= 1'b1;
          RF_W_addr  <= RA_W'(ir_d[RD_MSB:RD_LSB]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit (default build): vector table plus a per-instruction trace model.
module tb_control_unit;
  import cu_pkg::*;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic [15:0] IR_Data = '0;
  logic [6:0]  PC_Addr;
  logic [7:0]  D_Addr;
  logic        D_Wr, RF_s, RF_W_en;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr;
  logic [2:0]  ALU_s0;
  logic [3:0]  State;

  int nerr = 0;
  int nchk = 0;

  control_unit dut (
    .Clk(Clk), .ResetN(ResetN), .IR_Data(IR_Data), .PC_Addr(PC_Addr),
    .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s), .RF_W_addr(RF_W_addr),
    .RF_W_en(RF_W_en), .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
    .ALU_s0(ALU_s0), .State(State)
  );

  always #5 Clk = ~Clk;

  logic [15:0] rom [128];
  always @(posedge Clk) IR_Data <= rom[PC_Addr];

  typedef struct packed {
    logic [3:0] st;
    logic [6:0] pc;
    logic [7:0] da;
    logic       dw, rs, wen;
    logic [3:0] wa, ra, rb;
    logic [2:0] alu;
  } obs_t;

  typedef struct {
    logic [15:0] instr;
    int          cyc;
    obs_t        exp;
  } vec_t;

  obs_t trace[$];

  function automatic obs_t blank(state_t s, int pc);
    obs_t o = '0;
    o.st = s;
    o.pc = 7'(pc);
    return o;
  endfunction

  // Expected per-cycle outputs derived instruction by instruction from the ROM image.
  function automatic void build(int n);
    int pc = 0;
    logic [15:0] w;
    obs_t e;
    trace.delete();
    trace.push_back(blank(S_INIT, 0));
    while (trace.size() < n) begin
      w = rom[pc];
      trace.push_back(blank(S_FETCH, pc));
      trace.push_back(blank(S_DECODE, pc));
      pc = (pc + 1) % 128;
      case (w[15:12])
        4'd1: begin
          e = blank(S_STORE, pc); e.dw = 1; e.ra = w[11:8]; e.da = w[7:0];
          trace.push_back(e);
        end
        4'd2: begin
          e = blank(S_LOAD_A, pc); e.da = w[7:0];
          trace.push_back(e);
          e = blank(S_LOAD_B, pc); e.da = w[7:0]; e.rs = 1; e.wen = 1; e.wa = w[11:8];
          trace.push_back(e);
        end
        4'd3, 4'd4: begin
          e = blank(w[15:12] == 4'd3 ? S_ADD : S_SUB, pc);
          e.ra = w[7:4]; e.rb = w[3:0]; e.wen = 1; e.wa = w[11:8];
          e.alu = (w[15:12] == 4'd3) ? 3'd1 : 3'd2;
          trace.push_back(e);
        end
        4'd5: while (trace.size() < n) trace.push_back(blank(S_HALT, pc));
        default: trace.push_back(blank(S_NOOP, pc));
      endcase
    end
  endfunction

  function automatic obs_t sample();
    return {State, PC_Addr, D_Addr, D_Wr, RF_s, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr, ALU_s0};
  endfunction

  task automatic check(string nm, int cyc, obs_t exp);
    obs_t act = sample();
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d: got st=%0d pc=%0d da=%h dw=%b rs=%b wen=%b wa=%h ra=%h rb=%h alu=%0d, expected st=%0d pc=%0d da=%h dw=%b rs=%b wen=%b wa=%h ra=%h rb=%h alu=%0d",
               nm, cyc, act.st, act.pc, act.da, act.dw, act.rs, act.wen, act.wa, act.ra, act.rb, act.alu,
               exp.st, exp.pc, exp.da, exp.dw, exp.rs, exp.wen, exp.wa, exp.ra, exp.rb, exp.alu);
    end
  endtask

  // Leaves the bench just after reset release, in the INIT cycle.
  task automatic restart();
    ResetN = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset_state", -1, '0);
    ResetN = 1'b1;
    #1;
  endtask

  task automatic run_trace(string nm, int n);
    build(n);
    restart();
    check(nm, 0, trace[0]);
    for (int i = 1; i < n; i++) begin
      @(negedge Clk);
      check(nm, i, trace[i]);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
  endtask

  vec_t vt[11];

  initial begin
    vt[0]  = '{16'h5000, 3,  obs_t'({4'd9, 7'd1, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0})};
    vt[1]  = '{16'h5000, 22, obs_t'({4'd9, 7'd1, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0})};
    vt[2]  = '{16'h2305, 3,  obs_t'({4'd5, 7'd1, 8'h05, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0})};
    vt[3]  = '{16'h2305, 4,  obs_t'({4'd6, 7'd1, 8'h05, 1'b0, 1'b1, 1'b1, 4'h3, 4'h0, 4'h0, 3'd0})};
    vt[4]  = '{16'h2305, 5,  obs_t'({4'd1, 7'd1, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0})};
    vt[5]  = '{16'h3712, 3,  obs_t'({4'd7, 7'd1, 8'h00, 1'b0, 1'b0, 1'b1, 4'h7, 4'h1, 4'h2, 3'd1})};
    vt[6]  = '{16'h4712, 3,  obs_t'({4'd8, 7'd1, 8'h00, 1'b0, 1'b0, 1'b1, 4'h7, 4'h1, 4'h2, 3'd2})};
    vt[7]  = '{16'h1A40, 3,  obs_t'({4'd4, 7'd1, 8'h40, 1'b1, 1'b0, 1'b0, 4'h0, 4'hA, 4'h0, 3'd0})};
    vt[8]  = '{16'h9ABC, 3,  obs_t'({4'd3, 7'd1, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0})};
    vt[9]  = '{16'h0000, 4,  obs_t'({4'd1, 7'd1, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0})};
    vt[10] = '{16'h3712, 6,  obs_t'({4'd9, 7'd2, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0})};

    clear_rom();
    for (int v = 0; v < 11; v++) begin
      clear_rom();
      rom[0] = vt[v].instr;
      rom[1] = 16'h5000;
      restart();
      repeat (vt[v].cyc) @(negedge Clk);
      check($sformatf("vec%0d", v), vt[v].cyc, vt[v].exp);
    end

    clear_rom();
    rom[0] = 16'h5000;
    run_trace("halt_hold", 25);

    clear_rom();
    rom[0] = 16'h2305; rom[1] = 16'h3712; rom[2] = 16'h1A40; rom[3] = 16'h4712; rom[4] = 16'h5000;
    run_trace("mixed_prog", 25);

    clear_rom();
    run_trace("noop_wrap", 3 * 128 + 20);

    // Asynchronous reset in the middle of a LOAD.
    clear_rom();
    rom[0] = 16'h2305;
    run_trace("pre_abort", 4);
    #2 ResetN = 1'b0;
    #1 check("async_reset", 3, '0);
    run_trace("refetch", 10);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 128; i++) begin
        logic [31:0] rnd = $urandom();
        logic [3:0]  op  = 4'($urandom_range(0, 15));
        if (r == 0 && op == 4'd5) op = 4'd0;
        rom[i] = {op, rnd[11:0]};
      end
      run_trace($sformatf("random%0d", r), 700);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
